// File: rtl/qea_pkg.sv
// qea_pkg: shared FSM state encoding and lane/offset helpers
// used by the QEA host sequencer and its testbench-facing blocks.
package qea_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_CTX,
    S_INIT_ST,
    S_START,
    S_WAIT_CMP,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_HOLD,
    S_DONE
  } state_t;

  // LSB of the top lane of a state word
  function automatic int top_lane_lsb(
    int pe_num,
    int sdw,
    int dw
  );
    return pe_num * sdw - dw;
  endfunction

  // index of the last state word for a qubit count
  function automatic logic [31:0] last_word(
    int qbit,
    int pe_w
  );
    return (32'd1 << (qbit - pe_w)) - 32'd1;
  endfunction

  function automatic int min_qbit(int pe_w);
    return pe_w + 1;
  endfunction

  function automatic int max_qbit(int pe_w, int aw);
    return aw + pe_w;
  endfunction

endpackage

// File: rtl/qea_host_sequencer_if.sv
// qea_host_sequencer_if: upstream context stream and result stream.
// master = sequencer side, slave = host/testbench side.
interface qea_host_sequencer_if #(
  parameter int CTX_W  = 64,
  parameter int DOUT_W = 256
);

  logic              i_ctx_valid;
  logic [CTX_W-1:0]  i_ctx_data;
  logic              o_ctx_ready;
  logic              o_dout_valid;
  logic [DOUT_W-1:0] o_dout_data;
  logic              i_dout_ready;

  modport master (
    input  i_ctx_valid,
    input  i_ctx_data,
    input  i_dout_ready,
    output o_ctx_ready,
    output o_dout_valid,
    output o_dout_data
  );

  modport slave (
    output i_ctx_valid,
    output i_ctx_data,
    output i_dout_ready,
    input  o_ctx_ready,
    input  o_dout_valid,
    input  o_dout_data
  );

endinterface

// File: rtl/qea_out_slice.sv
// qea_out_slice: one-entry valid/ready holding register.
// Ports: clk, rst, load/load_data in, ready in, valid/data out.
module qea_out_slice #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads gate context, inits state RAM, starts QEA, streams results.
// Ports: clk/rst, job start (i_go, i_qbit_num, i_ins_num), bus (ctx/result streams), ctx + state RAM ports, start/complete, busy/done/err.
module qea_host_sequencer
  import qea_pkg::*;
#(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LAT                  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic [MAX_QBIT_WIDTH-1:0] i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  qea_host_sequencer_if.master bus,
  output logic o_ctx_en,
  output logic o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic o_state_ena,
  output logic o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0] o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
  output logic o_start,
  input  logic i_complete,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
  localparam int SAW = STATE_ADDR_WIDTH;
  localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
  localparam int TOP_LSB =
    top_lane_lsb(PE_NUM, STATE_DATA_WIDTH, DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] ONE_FX =
    DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // amplitude 1.0 of |0..0> in the top lane of word 0
  localparam logic [SW-1:0] INIT_WORD = SW'(ONE_FX) << TOP_LSB;

  state_t state;
  state_t nxt;

  logic [MAX_QBIT_WIDTH-1:0] qbit_r;
  logic [CAW-1:0] ins_r;
  logic [CAW-1:0] ctx_cnt;
  logic [SAW-1:0] st_cnt;
  logic [7:0] lat_cnt;
  logic [SAW-1:0] n_last;

  logic go_bad;
  logic ctx_hs;
  logic ctx_last;
  logic st_last;
  logic lat_done;
  logic out_hs;
  logic out_load;

  assign go_bad =
    (int'(i_qbit_num) < min_qbit(PE_NUM_WIDTH)) ||
    (int'(i_qbit_num) > max_qbit(PE_NUM_WIDTH, SAW));

  assign n_last = SAW'(last_word(int'(qbit_r), PE_NUM_WIDTH));

  assign ctx_hs   = bus.i_ctx_valid && (state == S_LOAD_CTX);
  assign ctx_last = (ctx_cnt == ins_r - CAW'(1));
  assign st_last  = (st_cnt == n_last);
  assign lat_done = (lat_cnt == 8'(RD_LAT - 1));
  assign out_hs   = bus.o_dout_valid && bus.i_dout_ready;
  assign out_load = (state == S_RD_WAIT) && lat_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (i_go && !go_bad)
          nxt = (i_ins_num == '0) ? S_INIT_ST : S_LOAD_CTX;
      S_LOAD_CTX:
        if (ctx_hs && ctx_last) nxt = S_INIT_ST;
      S_INIT_ST:
        if (st_last) nxt = S_START;
      S_START:
        nxt = S_WAIT_CMP;
      S_WAIT_CMP:
        if (i_complete) nxt = S_RD_REQ;
      S_RD_REQ:
        nxt = S_RD_WAIT;
      S_RD_WAIT:
        if (lat_done) nxt = S_RD_HOLD;
      S_RD_HOLD:
        if (out_hs) nxt = st_last ? S_DONE : S_RD_REQ;
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_ctx_ready = 1'b0;
    o_state_ena     = 1'b0;
    o_state_wea     = 1'b0;
    o_state_addra   = '0;
    o_state_dina    = '0;
    o_start         = 1'b0;
    o_done          = 1'b0;
    o_busy          = (state != S_IDLE);
    unique case (state)
      S_LOAD_CTX: bus.o_ctx_ready = 1'b1;
      S_INIT_ST: begin
        o_state_ena   = 1'b1;
        o_state_wea   = 1'b1;
        o_state_addra = st_cnt;
        o_state_dina  = (st_cnt == '0) ? INIT_WORD : '0;
      end
      S_START: o_start = 1'b1;
      S_RD_REQ: begin
        o_state_ena   = 1'b1;
        o_state_addra = st_cnt;
      end
      S_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qbit_r     <= '0;
      ins_r      <= '0;
      ctx_cnt    <= '0;
      st_cnt     <= '0;
      lat_cnt    <= '0;
      o_err      <= 1'b0;
      o_ctx_en   <= 1'b0;
      o_ctx_wea  <= 1'b0;
      o_ctx_addr <= '0;
      o_ctx_data <= '0;
    end else begin
      o_err     <= 1'b0;
      o_ctx_en  <= 1'b0;
      o_ctx_wea <= 1'b0;
      unique case (state)
        S_IDLE:
          if (i_go) begin
            qbit_r  <= i_qbit_num;
            ins_r   <= i_ins_num;
            o_err   <= go_bad;
            ctx_cnt <= '0;
            st_cnt  <= '0;
          end
        S_LOAD_CTX:
          if (ctx_hs) begin
            o_ctx_en   <= 1'b1;
            o_ctx_wea  <= 1'b1;
            o_ctx_addr <= ctx_cnt;
            o_ctx_data <= bus.i_ctx_data;
            ctx_cnt    <= ctx_last ? '0 : ctx_cnt + CAW'(1);
          end
        S_INIT_ST:
          st_cnt <= st_last ? '0 : st_cnt + SAW'(1);
        S_RD_REQ:
          lat_cnt <= '0;
        S_RD_WAIT:
          lat_cnt <= lat_cnt + 8'd1;
        S_RD_HOLD:
          if (out_hs && !st_last) st_cnt <= st_cnt + SAW'(1);
        S_DONE:
          st_cnt <= '0;
        default: ;
      endcase
    end
  end

  qea_out_slice #(
    .W(SW)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data (i_state_dout),
    .ready     (bus.i_dout_ready),
    .valid     (bus.o_dout_valid),
    .data      (bus.o_dout_data)
  );

endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: table vectors, directed corner cases and
// randomized jobs checked against a job-level reference model.
module tb_qea_host_sequencer;

  localparam int SW = 256;
  localparam logic [SW-1:0] INIT_W = {32'h4000_0000, 224'h0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic go = 1'b0;
  logic [5:0] qbit = '0;
  logic [15:0] ins = '0;
  logic ctx_en, ctx_wea;
  logic [15:0] ctx_addr;
  logic [63:0] ctx_data;
  logic st_ena, st_wea;
  logic [15:0] st_addr;
  logic [SW-1:0] st_dina;
  logic [SW-1:0] st_dout = '0;
  logic start, busy, done, err;
  logic complete = 1'b0;

  qea_host_sequencer_if #(.CTX_W(64), .DOUT_W(SW)) bus_if ();

  qea_host_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .i_go          (go),
    .i_qbit_num    (qbit),
    .i_ins_num     (ins),
    .bus           (bus_if),
    .o_ctx_en      (ctx_en),
    .o_ctx_wea     (ctx_wea),
    .o_ctx_addr    (ctx_addr),
    .o_ctx_data    (ctx_data),
    .o_state_ena   (st_ena),
    .o_state_wea   (st_wea),
    .o_state_addra (st_addr),
    .o_state_dina  (st_dina),
    .i_state_dout  (st_dout),
    .o_start       (start),
    .i_complete    (complete),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err)
  );

  // dummy state RAM: a read returns its address as data
  always @(posedge clk)
    if (st_ena && !st_wea) st_dout <= SW'(st_addr);

  int n_cmp = 0;
  int n_bad = 0;
  int cmp_delay = 1;
  int rdy_lo = 0;
  int rdy_hi = 0;

  logic [63:0] feed_q[$];
  int gap_q[$];

  logic [15:0] ctx_a_q[$];
  logic [63:0] ctx_d_q[$];
  logic [15:0] st_a_q[$];
  logic [SW-1:0] st_d_q[$];
  logic [SW-1:0] out_q[$];
  int n_start, n_done, n_err, n_busy, unstable, bad_wea;

  task automatic check(string nm, logic [SW-1:0] act,
                       logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    ctx_a_q.delete(); ctx_d_q.delete();
    st_a_q.delete(); st_d_q.delete(); out_q.delete();
    n_start = 0; n_done = 0; n_err = 0;
    n_busy = 0; unstable = 0; bad_wea = 0;
  endtask

  task automatic load_feed(int n, int gmax);
    for (int i = 0; i < n; i++) begin
      feed_q.push_back({$urandom, $urandom});
      gap_q.push_back(int'($urandom_range(gmax, 0)));
    end
  endtask

  function automatic logic any_out();
    return bus_if.o_ctx_ready | ctx_en | ctx_wea | (|ctx_addr) |
           (|ctx_data) | st_ena | st_wea | (|st_addr) | (|st_dina) |
           start | bus_if.o_dout_valid | (|bus_if.o_dout_data) |
           busy | done | err;
  endfunction

  // context feeder: optional idle gap before each word
  initial begin
    bit hs;
    bus_if.i_ctx_valid = 1'b0;
    bus_if.i_ctx_data = '0;
    forever begin
      @(negedge clk);
      hs = bus_if.i_ctx_valid && bus_if.o_ctx_ready;
      @(posedge clk);
      #1;
      if (hs && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        void'(gap_q.pop_front());
      end
      if (feed_q.size() > 0) begin
        if (gap_q[0] > 0) begin
          bus_if.i_ctx_valid = 1'b0;
          gap_q[0] = gap_q[0] - 1;
        end else begin
          bus_if.i_ctx_valid = 1'b1;
          bus_if.i_ctx_data = feed_q[0];
        end
      end else begin
        bus_if.i_ctx_valid = 1'b0;
      end
    end
  end

  // result sink: holds ready low for a chosen number of cycles per word
  initial begin
    int low, tgt;
    bus_if.i_dout_ready = 1'b0;
    low = 0;
    tgt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus_if.o_dout_valid) begin
        bus_if.i_dout_ready = 1'b0;
        low = 0;
        tgt = int'($urandom_range(rdy_hi, rdy_lo));
      end else if (low < tgt) begin
        bus_if.i_dout_ready = 1'b0;
        low++;
      end else begin
        bus_if.i_dout_ready = 1'b1;
      end
    end
  end

  // QEA model: completion level some cycles after start
  initial begin
    int cnt;
    bit armed;
    cnt = 0;
    armed = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        complete = 1'b0;
        armed = 0;
      end else if (start) begin
        complete = 1'b0;
        armed = 1;
        cnt = cmp_delay;
      end else if (armed) begin
        if (cnt <= 1) begin
          complete = 1'b1;
          armed = 0;
        end else begin
          cnt--;
        end
      end
      if (done) complete = 1'b0;
    end
  end

  // monitor
  initial begin
    logic prev_stall;
    logic [SW-1:0] prev_data;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (ctx_en) begin
          ctx_a_q.push_back(ctx_addr);
          ctx_d_q.push_back(ctx_data);
          if (!ctx_wea) bad_wea++;
        end
        if (st_ena && st_wea) begin
          st_a_q.push_back(st_addr);
          st_d_q.push_back(st_dina);
        end
        if (start) n_start++;
        if (done) n_done++;
        if (err) n_err++;
        if (busy) n_busy++;
        if (bus_if.o_dout_valid && bus_if.i_dout_ready)
          out_q.push_back(bus_if.o_dout_data);
        if (prev_stall && bus_if.o_dout_data !== prev_data)
          unstable++;
        prev_stall = bus_if.o_dout_valid && !bus_if.i_dout_ready;
        prev_data = bus_if.o_dout_data;
      end
    end
  end

  task automatic run_job(int q, int n_ins, bit exp_err,
                         int exp_words, int cdly, bit go_again,
                         string tag);
    logic [63:0] exp_ctx[$];
    logic [SW-1:0] e;
    bit fin;
    int since;
    exp_ctx = feed_q;
    clr_mon();
    cmp_delay = cdly;
    @(negedge clk);
    go = 1'b1;
    qbit = q[5:0];
    ins = n_ins[15:0];
    @(negedge clk);
    go = 1'b0;
    fin = 0;
    since = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      if (go_again) begin
        if (go) begin
          go = 1'b0;
        end else if (n_start > 0) begin
          since++;
          if (since == 6) begin
            go = 1'b1;
            qbit = 6'd6;
            ins = 16'd1;
          end
        end
      end
      if (n_done > 0 || (exp_err && c >= 4)) fin = 1;
    end
    check({tag, "_finish"}, fin, 1);
    repeat (4) @(negedge clk);
    feed_q.delete();
    gap_q.delete();
    check({tag, "_err"}, n_err, exp_err ? 1 : 0);
    check({tag, "_ctx_n"}, ctx_a_q.size(), exp_err ? 0 : n_ins);
    check({tag, "_wea"}, bad_wea, 0);
    for (int i = 0; i < ctx_a_q.size() && i < exp_ctx.size(); i++) begin
      check($sformatf("%s_ctx_a%0d", tag, i), ctx_a_q[i], i);
      check($sformatf("%s_ctx_d%0d", tag, i), ctx_d_q[i], exp_ctx[i]);
    end
    check({tag, "_st_n"}, st_a_q.size(), exp_words);
    for (int i = 0; i < st_a_q.size() && i < exp_words; i++) begin
      e = (i == 0) ? INIT_W : '0;
      check($sformatf("%s_st_a%0d", tag, i), st_a_q[i], i);
      check($sformatf("%s_st_d%0d", tag, i), st_d_q[i], e);
    end
    check({tag, "_start"}, n_start, exp_err ? 0 : 1);
    check({tag, "_out_n"}, out_q.size(), exp_words);
    for (int i = 0; i < out_q.size() && i < exp_words; i++) begin
      e = SW'(i);
      check($sformatf("%s_out%0d", tag, i), out_q[i], e);
    end
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_done"}, n_done, exp_err ? 0 : 1);
    if (exp_err) check({tag, "_busy"}, n_busy, 0);
    else check({tag, "_busy"}, n_busy > 0, 1);
  endtask

  typedef struct {
    int q;
    int n;
    bit err;
    int words;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 0, 1, 0};
    tbl[1] = '{19, 0, 1, 0};
    tbl[2] = '{2, 2, 1, 0};
    tbl[3] = '{0, 1, 1, 0};
    tbl[4] = '{63, 1, 1, 0};
    tbl[5] = '{3, 0, 0, 2};
    tbl[6] = '{3, 2, 0, 2};
    tbl[7] = '{5, 1, 0, 8};
    clr_mon();

    repeat (3) @(negedge clk);
    check("reset_outs", any_out(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", any_out(), 0);

    // three ctx words with a 2-cycle stall before the second,
    // late completion, slow result sink
    load_feed(3, 0);
    gap_q[1] = 2;
    rdy_lo = 3;
    rdy_hi = 3;
    run_job(4, 3, 0, 4, 50, 0, "basic");

    rdy_lo = 0;
    rdy_hi = 1;
    for (int i = 0; i < 8; i++) begin
      load_feed(tbl[i].n, 1);
      run_job(tbl[i].q, tbl[i].n, tbl[i].err, tbl[i].words, 4, 0,
              $sformatf("vec%0d", i));
    end

    // a second go while waiting for completion must be ignored
    run_job(4, 0, 0, 4, 50, 1, "go_wait");

    // reset in the middle of state init
    clr_mon();
    cmp_delay = 5;
    @(negedge clk);
    go = 1'b1;
    qbit = 6'd6;
    ins = 16'd0;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 50 && st_a_q.size() < 3; c++) @(negedge clk);
    check("rst_in_init", st_a_q.size() >= 3, 1);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", any_out(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_mon();
    repeat (5) @(negedge clk);
    check("post_rst_quiet", n_busy + n_start + st_a_q.size(), 0);
    run_job(3, 0, 0, 2, 3, 0, "post_rst");

    // random jobs against the job-level model
    for (int r = 0; r < 8; r++) begin
      int q, n, nw;
      bit e;
      q = int'($urandom_range(7, 0));
      if (q > 5) q = q + 13;
      n = int'($urandom_range(5, 0));
      e = (q < 3) || (q > 18);
      nw = e ? 0 : (1 << (q - 2));
      rdy_lo = 0;
      rdy_hi = 2;
      load_feed(n, 2);
      run_job(q, n, e, nw, int'($urandom_range(20, 1)), 0,
              $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qea_host_sequencer.md
QEA_HOST_SEQUENCER -- requirements
Module: qea_host_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PE_NUM_WIDTH, 2, log2 of PE count
- PE_NUM, 4, PE lanes per state word
- DATA_WIDTH, 32, real/imag part width
- STATE_DATA_WIDTH, 64, one complex amplitude
- STATE_ADDR_WIDTH, 16, state RAM address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context address width
- MAX_QBIT_WIDTH, 6, qubit-count field width
- NUM_FRAC_BIT, 30, fixed-point fraction bits
- RD_LAT, 1, QEA state read latency in cycles

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous active-high reset
- i_go, in, 1, one-cycle pulse that starts one job
- i_qbit_num, in, MAX_QBIT_WIDTH, qubit count for the job
- i_ins_num, in, GATE_CONTEXT_ADDR_WIDTH, number of context words
- i_ctx_valid, in, 1, upstream context word valid
- i_ctx_data, in, GATE_CONTEXT_DATA_WIDTH, upstream context word
- o_ctx_ready, out, 1, context word accepted
- o_ctx_en, out, 1, QEA context write port enable
- o_ctx_wea, out, 1, QEA context write port write enable
- o_ctx_addr, out, GATE_CONTEXT_ADDR_WIDTH, QEA context write port address
- o_ctx_data, out, GATE_CONTEXT_DATA_WIDTH, QEA context write port data
- o_state_ena, out, 1, QEA state port enable
- o_state_wea, out, 1, QEA state port write enable
- o_state_addra, out, STATE_ADDR_WIDTH, QEA state port address
- o_state_dina, out, PE_NUM*STATE_DATA_WIDTH, QEA state port write data
- i_state_dout, in, PE_NUM*STATE_DATA_WIDTH, QEA state read data
- o_start, out, 1, QEA start pulse
- i_complete, in, 1, QEA completion level
- o_dout_valid, out, 1, result stream valid
- o_dout_data, out, PE_NUM*STATE_DATA_WIDTH, result stream data
- i_dout_ready, in, 1, result stream ready
- o_busy, out, 1, job in progress
- o_done, out, 1, one-cycle pulse at job end
- o_err, out, 1, one-cycle pulse when a job is rejected

Function
REQ-003 FSM states SHALL be IDLE, LOAD_CTX, INIT_ST, START, WAIT_CMP, RD_REQ, RD_WAIT, RD_HOLD, DONE.
REQ-004 In IDLE, i_go SHALL latch i_qbit_num and i_ins_num; i_go SHALL be ignored outside IDLE.
REQ-005 A job with i_qbit_num < PE_NUM_WIDTH+1 or > STATE_ADDR_WIDTH+PE_NUM_WIDTH SHALL be rejected: o_err pulses the next cycle and the FSM stays in IDLE.
REQ-006 Valid jobs SHALL enter LOAD_CTX, or INIT_ST directly when ins_num = 0.
REQ-007 LOAD_CTX timing and exit:
- o_ctx_ready = 1 in this state.
- Each i_ctx_valid&&o_ctx_ready handshake registers en=wea=1, the data, and addr = count (from 0) on the next cycle.
- The FSM exits after ins_num handshakes.
REQ-008 INIT_ST SHALL write N = 2**(qbit_num-PE_NUM_WIDTH) words at addresses 0..N-1, one per cycle, with ena=wea=1.
- All words are zero except address 0.
- At address 0, the top lane (bits [PE_NUM*STATE_DATA_WIDTH-1 -: DATA_WIDTH]) holds 1<<NUM_FRAC_BIT.
REQ-009 START SHALL assert o_start for exactly one cycle, then enter WAIT_CMP until i_complete = 1.
REQ-010 The readout loop SHALL work as follows:
- RD_REQ drives ena=1, wea=0, addr=k for one cycle.
- RD_WAIT lasts RD_LAT cycles, then captures i_state_dout into o_dout_data.
- RD_HOLD holds o_dout_valid=1 with data stable until i_dout_ready.
- The loop runs for k = 0..N-1.
REQ-011 After the last handshake, DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-012 o_busy SHALL be 1 in every state except IDLE.
REQ-013 Address counters SHALL never exceed N-1 or ins_num-1; no write SHALL occur in any other state.

Reset
REQ-014 rst SHALL asynchronously force IDLE and zero every output and counter, including mid-job; no partial pulse SHALL follow deassertion.

Structure
REQ-015 The FSM state enum and the lane/offset constants SHALL live in shared package qea_pkg.
REQ-016 The result output register SHALL be one sub-module, qea_out_slice: a one-entry valid/ready holding register.

Verification
REQ-017 ins_num=3 with ctx words A,B,C, valid stalled 2 cycles before B -> three writes at addr 0,1,2 carrying A,B,C, each with en=wea=1.
REQ-018 qbit_num=4 -> 4 init writes; word 0 = 0x40000000_00000000 in the top lane with the rest zero, words 1..3 zero; o_start high exactly 1 cycle.
REQ-019 i_complete raised 50 cycles after o_start, dummy RAM returns addr as data, i_dout_ready held low 3 cycles per word -> 4 output words 0..3 in order, data stable while stalled, then o_done pulse.
REQ-020 i_go with qbit_num=1, then qbit_num=19 -> o_err pulse each time, no ctx/state writes, o_busy stays 0.
REQ-021 rst asserted during INIT_ST -> all outputs 0 at once; a new i_go with qbit_num=3 then runs a full job normally.
REQ-022 i_go pulsed during WAIT_CMP -> ignored; the latched parameters are unchanged.
